// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the EX-stage multiply/divide unit.
//   - md_op encodings (MD_NONE .. MD_MTLO); 3'd7 is reserved and behaves as MD_NONE
//   - mul/div state machine encoding (MD_IDLE, MD_PREP, MD_RUN, MD_FIX)
//   - MD_ITERS: RUN cycles per multiply/divide (one result bit per cycle)
package mips_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int unsigned MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_PREP = 2'd1,
        MD_RUN  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    // Signed variants take operand magnitudes and fix the sign afterwards.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: shared radix-2 iterative datapath for the multiply/divide unit.
//   One 64-bit accumulator, one 33-bit adder/subtractor, a 6-bit step counter.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     load_i        load operands: acc = {0, a_i}, m = b_i, counter cleared
//     step_i        perform one iteration
//     div_i         1 = restoring divide step, 0 = shift-add multiply step
//     a_i, b_i      unsigned magnitudes (multiplier/dividend, multiplicand/divisor)
//     acc_o         multiply: 64-bit product; divide: {remainder, quotient}
//     last_o        the current step is the final one
module mul_div_iter
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               last_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q;
    logic [5:0]         cnt_q;

    logic [WIDTH:0] add_x, add_y, add_y_op, add_sum;
    logic           add_sub;

    always_comb begin
        if (div_i) begin
            // Shift the partial remainder left by one, pulling in the next
            // dividend bit, and trial-subtract the divisor.
            add_x   = acc_q[2*WIDTH-1:WIDTH-1];
            add_y   = {1'b0, m_q};
            add_sub = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y   = acc_q[0] ? {1'b0, m_q} : '0;
            add_sub = 1'b0;
        end
        add_y_op = add_sub ? ~add_y : add_y;
        add_sum  = add_x + add_y_op + {{WIDTH{1'b0}}, add_sub};

        if (div_i) begin
            // The partial remainder is always below the divisor, so the trial
            // difference fits in WIDTH bits and bit WIDTH flags a borrow.
            if (add_sum[WIDTH]) begin
                acc_d = {add_x[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Carry-out of the add becomes the new top bit as everything
            // shifts right, retiring one multiplier bit.
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            m_q   <= b_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == 6'(MD_ITERS - 1));

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
// plus MTHI/MTLO writes. md_busy stalls the pipeline while an op is in flight.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     md_start     request, accepted only while md_busy = 0
//     md_op        operation select (see mips_pkg encodings)
//     md_a, md_b   rs / rt operands
//     md_busy      state machine not IDLE
//     md_done      one-cycle pulse when a mul/div result lands in HI/LO
//     hi, lo       HI / LO registers
//   Configuration:
//     MULDIV_FAST_MUL_EN  when defined, MULT/MULTU complete in one cycle via a
//                         combinational multiply; divides stay iterative.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             div_q, div_d;

    logic             it_load, it_step, it_last;
    logic [2*WIDTH-1:0] it_acc;

    // Operand magnitudes and result signs, derived from the latched operands.
    logic             a_neg, b_neg, q_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    always_comb begin
        if (md_is_signed(md_op)) begin
            fast_prod = $signed({{WIDTH{md_a[WIDTH-1]}}, md_a})
                      * $signed({{WIDTH{md_b[WIDTH-1]}}, md_b});
        end else begin
            fast_prod = {{WIDTH{1'b0}}, md_a} * {{WIDTH{1'b0}}, md_b};
        end
    end
`endif

    always_comb begin
        a_neg = signed_q & a_q[WIDTH-1];
        b_neg = signed_q & b_q[WIDTH-1];
        q_neg = a_neg ^ b_neg;
        a_mag = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag = b_neg ? (~b_q + 1'b1) : b_q;

        quo  = it_acc[WIDTH-1:0];
        rem  = it_acc[2*WIDTH-1:WIDTH];
        prod = q_neg ? (~it_acc + 1'b1) : it_acc;

        if (div_q) begin
            if (b_q == '0) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                // 0x8000_0000 / -1 needs no special case: the magnitude
                // quotient 0x8000_0000 negates to itself.
                fix_lo = q_neg ? (~quo + 1'b1) : quo;
                fix_hi = a_neg ? (~rem + 1'b1) : rem;
            end
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        div_d    = div_q;
        it_load  = 1'b0;
        it_step  = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        MD_MTHI: hi_d = md_a;
                        MD_MTLO: lo_d = md_a;
`ifdef MULDIV_FAST_MUL_EN
                        MD_MULT, MD_MULTU: begin
                            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d   = fast_prod[WIDTH-1:0];
                            done_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
`else
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
`endif
                            a_d      = md_a;
                            b_d      = md_b;
                            signed_d = md_is_signed(md_op);
                            div_d    = md_is_div(md_op);
                            state_d  = MD_PREP;
                        end
                        default: ;
                    endcase
                end
            end
            MD_PREP: begin
                it_load = 1'b1;
                state_d = MD_RUN;
            end
            MD_RUN: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            div_q    <= div_d;
        end
    end

    mul_div_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load_i (it_load),
        .step_i (it_step),
        .div_i  (div_q),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (it_acc),
        .last_o (it_last)
    );

    assign md_busy = (state_q != MD_IDLE);
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized + directed bench for mul_div_unit against an
// arithmetic reference model of HI/LO results and cycle timing.
module tb_mul_div_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        md_busy, md_done;
    logic [31:0] hi, lo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one request plus the number of samples until it
    // is visible (35 for iterative ops, 1 otherwise).
    function automatic void ref_model(
        input  logic [2:0]  op,
        input  logic [31:0] a, b, hi_in, lo_in,
        output logic [31:0] hi_out, lo_out,
        output bit          done_out, busy_out,
        output int unsigned lat_out
    );
        longint      sa, sb, sp;
        logic [63:0] up;
        hi_out = hi_in; lo_out = lo_in;
        done_out = 1'b0; busy_out = 1'b0; lat_out = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MTHI: hi_out = a;
            MD_MTLO: lo_out = a;
            MD_MULT, MD_MULTU: begin
                if (op == MD_MULT) begin
                    sp = sa * sb;
                    up = 64'(sp);
                end else begin
                    up = {32'b0, a} * {32'b0, b};
                end
                hi_out = up[63:32];
                lo_out = up[31:0];
                done_out = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                lat_out = 1;
`else
                lat_out = 35; busy_out = 1'b1;
`endif
            end
            MD_DIV, MD_DIVU: begin
                done_out = 1'b1; lat_out = 35; busy_out = 1'b1;
                if (b == 32'd0) begin
                    lo_out = 32'hFFFF_FFFF;
                    hi_out = a;
                end else if (op == MD_DIV) begin
                    lo_out = 32'(sa / sb);
                    hi_out = 32'(sa % sb);
                end else begin
                    lo_out = a / b;
                    hi_out = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one request from a negedge and follow it to completion. If
    // intrude > 0, a MULT request is presented during that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned intrude);
        logic [31:0] nh, nl;
        bit          dn, bz;
        int unsigned lat;
        ref_model(op, a, b, exp_hi, exp_lo, nh, nl, dn, bz, lat);
        check_eq("busy_before_issue", md_busy, 1'b0);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        md_op = 3'($urandom_range(0, 7));
        md_a = $urandom; md_b = $urandom;
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == intrude + 1) md_start = 1'b0;
            if (k < lat) begin
                check_eq("busy_inflight", md_busy, bz);
                check_eq("done_inflight", md_done, 1'b0);
                check_eq("hi_hold", hi, exp_hi);
                check_eq("lo_hold", lo, exp_lo);
            end else begin
                check_eq("busy_result", md_busy, 1'b0);
                check_eq("done_result", md_done, dn);
                check_eq("hi_result", hi, nh);
                check_eq("lo_result", lo, nl);
            end
            if (k == intrude && k + 1 < lat) begin
                md_start = 1'b1; md_op = MD_MULT; md_a = $urandom; md_b = $urandom;
            end
        end
        exp_hi = nh;
        exp_lo = nl;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; md_start = 1'b0; md_op = MD_NONE; md_a = '0; md_b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_busy", md_busy, 1'b0);
        check_eq("rst_done", md_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases.
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 0);
        run_op(MD_DIVU,  32'h1234_5678, 32'h0000_0000, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(MD_DIV,   32'hF000_0001, 32'h0000_0000, 0);
        run_op(MD_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0);
        run_op(MD_NONE,  32'h1111_1111, 32'h2222_2222, 0);
        run_op(3'd7,     32'h3333_3333, 32'h4444_4444, 0);

        // MTHI then MTLO on consecutive cycles.
        md_start = 1'b1; md_op = MD_MTHI; md_a = 32'hDEAD_BEEF; md_b = $urandom;
        @(posedge clk);
        #1;
        md_op = MD_MTLO; md_a = 32'h0BAD_F00D;
        @(negedge clk);
        check_eq("mthi_hi", hi, 32'hDEAD_BEEF);
        check_eq("mthi_lo", lo, exp_lo);
        check_eq("mthi_busy", md_busy, 1'b0);
        check_eq("mthi_done", md_done, 1'b0);
        @(posedge clk);
        #1;
        md_start = 1'b0;
        @(negedge clk);
        check_eq("mtlo_hi", hi, 32'hDEAD_BEEF);
        check_eq("mtlo_lo", lo, 32'h0BAD_F00D);
        check_eq("mtlo_busy", md_busy, 1'b0);
        check_eq("mtlo_done", md_done, 1'b0);
        exp_hi = 32'hDEAD_BEEF;
        exp_lo = 32'h0BAD_F00D;

        // Start while busy is ignored; back-to-back issue on the done cycle.
        run_op(MD_DIV,  32'hABCD_0123, 32'h0000_0135, 5);
        run_op(MD_MULT, 32'h0001_2345, 32'hFFFF_FFFD, 0);

        // Asynchronous reset in the middle of a divide.
        md_start = 1'b1; md_op = MD_DIV; md_a = 32'h7654_3210; md_b = 32'd7;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", md_busy, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_hi", hi, 32'd0);
        check_eq("async_rst_lo", lo, 32'd0);
        check_eq("async_rst_busy", md_busy, 1'b0);
        check_eq("async_rst_done", md_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        check_eq("post_rst_busy", md_busy, 1'b0);
        check_eq("post_rst_hi", hi, 32'd0);
        run_op(MD_DIVU, 32'd100, 32'd7, 0);

        // Randomized mix, biased toward divide/multiply corner operands.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(rop, ra, rb, (i % 4 == 0) ? 32'($urandom_range(1, 30)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
